key_debounce_array: RTL and testbench

- Parametrised multi-channel successor to the single-key debouncer, intended for elevator floor-call and cabin buttons.
- Per channel it provides:
  - a 2-flop synchroniser;
  - a consecutive-sample debouncer;
  - a per-channel press FSM that emits one-cycle press, release, long-press and auto-repeat pulses.
- Sits between the board button pins and the request-latching / floor-scheduling logic; all outputs are synchronous to clk.

---
 rtl/key_debounce_array.sv | 148 ++++++++++++++
 tb/tb_key_debounce_array.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// Multi-channel key conditioner: per channel a 2-flop synchroniser, a consecutive-sample
// debouncer and a press FSM that emits press/release/long/repeat one-cycle pulses.
module key_debounce_array #(
  parameter int CHANNELS        = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int HOLD_WIDTH      = 27,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key_in,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_pressed
);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  localparam logic [CNT_WIDTH-1:0]  DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] LONG_LAST = HOLD_WIDTH'(LONG_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] REP_LAST  =
    HOLD_WIDTH'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit REPEAT_EN = (REPEAT_CYCLES > 0);

  logic [CHANNELS-1:0] pin_log;
  assign pin_log = key_in ^ {CHANNELS{ACTIVE_LOW}};

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic                  sync1_q, sync2_q;
    logic                  level_q, level_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  rise, fall;
    state_t                state_q, state_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic [HOLD_WIDTH-1:0] rep_q, rep_d;
    logic                  press_q, release_q;
    logic                  long_q, long_d;
    logic                  repeat_q, repeat_d;

    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DB_LAST) begin
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      rise = level_d & ~level_q;
      fall = ~level_d & level_q;
    end

    // A debounced fall pre-empts any long/repeat event due on the same edge.
    always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      rep_d    = rep_q;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESSED;
            hold_d  = '0;
            rep_d   = '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_d = IDLE;
            hold_d  = '0;
            rep_d   = '0;
          end else if (hold_q == LONG_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
            hold_d  = '0;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        LONG: begin
          if (fall) begin
            state_d = IDLE;
            hold_d  = '0;
            rep_d   = '0;
          end else if (REPEAT_EN) begin
            if (rep_q == REP_LAST) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        cnt_q     <= '0;
        state_q   <= IDLE;
        hold_q    <= '0;
        rep_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync1_q   <= pin_log[g];
        sync2_q   <= sync1_q;
        level_q   <= level_d;
        cnt_q     <= cnt_d;
        state_q   <= state_d;
        hold_q    <= hold_d;
        rep_q     <= rep_d;
        press_q   <= rise;
        release_q <= fall;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign key_level[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
    assign long_pulse[g]    = long_q;
    assign repeat_pulse[g]  = repeat_q;
  end

  assign any_pressed = |key_level;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: directed scenarios then random pins, both polarities,
// every cycle compared against a sample-window / press-age reference model.
module tb_key_debounce_array;

  localparam int CH = 4;
  localparam int DB = 4;
  localparam int LC = 10;
  localparam int RC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] key_in = '0;
  logic [CH-1:0] key_in_n;
  assign key_in_n = ~key_in;

  logic [CH-1:0] h_lvl, h_prs, h_rel, h_lng, h_rep;
  logic          h_any;
  logic [CH-1:0] l_lvl, l_prs, l_rel, l_lng, l_rep;
  logic          l_any;

  key_debounce_array #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(4),
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .HOLD_WIDTH(5), .ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(h_lvl), .press_pulse(h_prs), .release_pulse(h_rel),
    .long_pulse(h_lng), .repeat_pulse(h_rep), .any_pressed(h_any)
  );

  key_debounce_array #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(4),
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .HOLD_WIDTH(5), .ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .rst(rst), .key_in(key_in_n),
    .key_level(l_lvl), .press_pulse(l_prs), .release_pulse(l_rel),
    .long_pulse(l_lng), .repeat_pulse(l_rep), .any_pressed(l_any)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pin delay line, window of last DB seen samples, press age.
  int            cyc = 0;
  bit            pipe0 [CH];
  bit            pipe1 [CH];
  bit            hist  [CH][DB];
  int            nsamp [CH];
  bit            lvl   [CH];
  bit            held  [CH];
  int            t_press [CH];
  logic [CH-1:0] e_lvl, e_prs, e_rel, e_lng, e_rep;

  task automatic model_edge(input logic r, input logic [CH-1:0] pins);
    bit seen;
    bit all_diff;
    int age;
    cyc++;
    e_prs = '0; e_rel = '0; e_lng = '0; e_rep = '0;
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        pipe0[c] = 1'b0; pipe1[c] = 1'b0;
        nsamp[c] = 0; lvl[c] = 1'b0; held[c] = 1'b0;
      end else begin
        seen = pipe1[c];
        pipe1[c] = pipe0[c];
        pipe0[c] = pins[c];
        for (int k = DB - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = seen;
        if (nsamp[c] < DB) nsamp[c]++;
        all_diff = (nsamp[c] == DB);
        for (int k = 0; k < DB; k++) if (hist[c][k] == lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          lvl[c]   = ~lvl[c];
          nsamp[c] = 0;
          if (lvl[c]) begin
            e_prs[c] = 1'b1; held[c] = 1'b1; t_press[c] = cyc;
          end else begin
            e_rel[c] = 1'b1; held[c] = 1'b0;
          end
        end else if (held[c]) begin
          age = cyc - t_press[c];
          if (age == LC) e_lng[c] = 1'b1;
          if (RC > 0 && age > LC && ((age - LC) % RC) == 0) e_rep[c] = 1'b1;
        end
      end
    end
    for (int c = 0; c < CH; c++) e_lvl[c] = lvl[c];
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst, key_in);
    #1;
    chk("h_level",   h_lvl, e_lvl);
    chk("h_press",   h_prs, e_prs);
    chk("h_release", h_rel, e_rel);
    chk("h_long",    h_lng, e_lng);
    chk("h_repeat",  h_rep, e_rep);
    chk("h_any",     {{(CH-1){1'b0}}, h_any}, {{(CH-1){1'b0}}, |e_lvl});
    chk("l_level",   l_lvl, e_lvl);
    chk("l_press",   l_prs, e_prs);
    chk("l_release", l_rel, e_rel);
    chk("l_long",    l_lng, e_lng);
    chk("l_repeat",  l_rep, e_rep);
    chk("l_any",     {{(CH-1){1'b0}}, l_any}, {{(CH-1){1'b0}}, |e_lvl});
  endtask

  initial begin
    // Reset with pins idle (ACTIVE_LOW instance sees all ones)
    rst = 1'b1; key_in = '0;
    repeat (3) tick();
    chk("rst_level_h", h_lvl, '0);
    chk("rst_level_l", l_lvl, '0);
    rst = 1'b0;
    tick();

    // Clean press on channel 0
    key_in[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) chk("clean_early", {3'b0, h_lvl[0]}, '0);
    end
    chk("clean_press_h", {3'b0, h_prs[0]}, 4'b0001);
    chk("clean_press_l", {3'b0, l_prs[0]}, 4'b0001);
    tick();
    chk("clean_pulse_width", {3'b0, h_prs[0]}, '0);
    chk("clean_any", {3'b0, h_any}, 4'b0001);

    // Bounce on channel 1
    for (int b = 0; b < 4; b++) begin
      key_in[1] = (b % 2 == 0);
      tick(); tick();
      chk("bounce_quiet", {3'b0, h_prs[1]}, '0);
    end
    key_in[1] = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    chk("bounce_press", {3'b0, h_prs[1]}, 4'b0001);

    // Long press and repeat on channel 2
    key_in[2] = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    chk("long_press", {3'b0, h_prs[2]}, 4'b0001);
    for (int i = 1; i <= 10; i++) tick();
    chk("long_pulse", {3'b0, h_lng[2]}, 4'b0001);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("repeat_seq", {3'b0, h_rep[2]}, {3'b0, (i % 3) == 0});
    end
    key_in[2] = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    chk("rel_over_repeat_rel", {3'b0, h_rel[2]}, 4'b0001);
    chk("rel_over_repeat_rep", {3'b0, h_rep[2]}, '0);
    repeat (8) tick();

    // Release debounced onto the long-press edge of channel 3
    key_in[3] = 1'b1;
    for (int i = 1; i <= 6; i++) tick();
    chk("coll_press", {3'b0, h_prs[3]}, 4'b0001);
    repeat (4) tick();
    key_in[3] = 1'b0;
    for (int i = 1; i <= 6; i++) tick();
    chk("coll_release", {3'b0, h_rel[3]}, 4'b0001);
    chk("coll_long", {3'b0, h_lng[3]}, '0);

    // Reset while channel 0 is long-pressed
    rst = 1'b1;
    tick();
    chk("midrst_level", h_lvl, '0);
    chk("midrst_release", h_rel | l_rel, '0);
    chk("midrst_pulses", h_prs | h_lng | h_rep, '0);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) chk("midrst_early", {3'b0, h_prs[0]}, '0);
    end
    chk("midrst_repress", {3'b0, h_prs[0]}, 4'b0001);

    // Random pins with mixed calm and bouncy phases, occasional reset
    key_in = '0;
    repeat (10) tick();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ((n / 200) % 3 == 1) begin
          if ($urandom_range(0, 99) < 25) key_in[c] = ~key_in[c];
        end else begin
          if ($urandom_range(0, 99) < 3) key_in[c] = ~key_in[c];
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
